// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: datapath widths, Q2.29 angle constants, arctangent table, gain.
package cordic_pkg;

  localparam int CORDIC_W  = 32;
  localparam int CORDIC_GW = 2;
  localparam int ATAN_N    = 30;

  // Angles are Q2.29 radians.
  localparam logic signed [31:0] PI         = 32'sd1686629713;
  localparam logic signed [31:0] HALF_PI    = 32'sd843314857;
  localparam logic signed [31:0] QUARTER_PI = 32'sd421657428;
  localparam logic signed [31:0] K_GAIN     = 32'sd884097682;

  // round(atan(2^-i) * 2^29)
  localparam logic [31:0] ATAN_TABLE [0:ATAN_N-1] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384,
    32'd8192,      32'd4096,      32'd2048,      32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,
    32'd32,        32'd16,        32'd8,         32'd4,
    32'd2,         32'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } cordic_state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup: ATAN[i] in Q2.29, zero beyond the table.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W
) (
  input  logic [4:0]   i,
  output logic [W-1:0] atan
);

  always_comb begin
    atan = '0;
    if (i < 5'(ATAN_N)) begin
      atan = W'(ATAN_TABLE[i]);
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: one micro-rotation per clock, result ITER+1 cycles after capture.
// Accepts a vector only in IDLE; the result is held in DONE until out_ready.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int W    = CORDIC_W,
  parameter int GW   = CORDIC_GW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] mag_out,
  output logic [W-1:0] angle_out
);

  localparam int XW = W + GW;
  localparam logic [4:0] LAST = 5'(ITER - 1);
  localparam logic signed [XW-1:0] MAG_MAX = $signed({{(GW + 1){1'b0}}, {(W - 1){1'b1}}});

  cordic_state_t state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic [W-1:0]         mag_q, mag_d, angle_q, angle_d;

  logic [W-1:0]         atan_i;
  logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh, x_rot, y_rot;
  logic signed [W-1:0]  z_rot;

  cordic_atan_lut #(.W(W)) u_atan_lut (
    .i    (cnt_q),
    .atan (atan_i)
  );

  assign x_ext = $signed({{GW{x_in[W-1]}}, x_in});
  assign y_ext = $signed({{GW{y_in[W-1]}}, y_in});
  assign x_sh  = x_q >>> cnt_q;
  assign y_sh  = y_q >>> cnt_q;

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign mag_out   = mag_q;
  assign angle_out = angle_q;

  always_comb begin
    x_rot = x_q;
    y_rot = y_q;
    z_rot = z_q;
    if (!y_q[XW-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + $signed(atan_i);
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - $signed(atan_i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Fold the left half-plane into the right so the iterations converge.
          if (!x_in[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_in[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = W'(HALF_PI);
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -W'(HALF_PI);
          end
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (cnt_q == LAST) begin
          mag_d   = (x_rot > MAG_MAX) ? MAG_MAX[W-1:0] : x_rot[W-1:0];
          angle_d = z_rot;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

endmodule
